// File: rtl/hub75_capture_if.sv
// Captured-line stream from hub75_capture to its consumer.
// The consumer acknowledges each line with tready.
interface hub75_capture_if #(
    parameter int unsigned NUM_COLS   = 64,
    parameter int unsigned NUM_PLANES = 3
);
    localparam int unsigned PW  = $clog2(NUM_COLS) + 1;
    localparam int unsigned PLW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;

    logic [NUM_COLS-1:0][2:0] col_data0;
    logic [NUM_COLS-1:0][2:0] col_data1;
    logic [PW-1:0]            pix_count;
    logic [PLW-1:0]           plane_index;
    logic                     tvalid;
    logic                     tready;

    modport master (
        output col_data0, col_data1, pix_count, plane_index, tvalid,
        input  tready
    );

    modport slave (
        input  col_data0, col_data1, pix_count, plane_index, tvalid,
        output tready
    );
endinterface

// File: rtl/hub75_capture.sv
// HUB75 panel-bus sniffer: captures each shifted row-pair line on latch,
// streams it out, and measures the OE on-time of each lit interval.
module hub75_capture #(
    parameter int unsigned NUM_COLS   = 64,
    parameter int unsigned NUM_PLANES = 3,
    parameter int unsigned TIMER_W    = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               led_clk,
    input  logic               led_latch,
    input  logic               led_output_enable,
    input  logic [2:0]         rgb0,
    input  logic [2:0]         rgb1,
    hub75_capture_if.master    m_axis,
    output logic [TIMER_W-1:0] on_time,
    output logic               on_time_valid,
    input  logic               clear_err,
    output logic               err_count,
    output logic               err_overflow
);
    localparam int unsigned PW  = $clog2(NUM_COLS) + 1;
    localparam int unsigned AW  = PW - 1;
    localparam int unsigned PLW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
    localparam int unsigned IW  = $clog2(4 * NUM_COLS + 1);

    localparam logic [PW-1:0]  COLS_P     = PW'(NUM_COLS);
    localparam logic [PLW-1:0] PLANE_LAST = PLW'(NUM_PLANES - 1);
    localparam logic [IW-1:0]  IDLE_LIM   = IW'(4 * NUM_COLS);
    localparam logic [8:0]     BUS_IDLE   = 9'b0_0_1_000_000;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    out_state_t state_q, state_d;
    logic       accept;

    logic [8:0] sync1, sync2;
    logic [2:0] edge_d;
    logic       clk_s, latch_s, oe_s;
    logic       clk_rise, latch_rise, oe_fall, oe_rise;
    logic [2:0] rgb0_s, rgb1_s;

    logic [NUM_COLS-1:0][2:0] wbuf0, wbuf1;
    logic [NUM_COLS-1:0][2:0] col0_q, col1_q;
    logic [PW-1:0]            ptr, pix_q;
    logic                     too_many;
    logic [PLW-1:0]           plane_cnt, plane_q;
    logic [IW-1:0]            idle_cnt;
    logic [TIMER_W-1:0]       timer;
    logic                     cnt_bad;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1  <= BUS_IDLE;
            sync2  <= BUS_IDLE;
            edge_d <= 3'b001;
        end else begin
            sync1  <= {led_clk, led_latch, led_output_enable, rgb1, rgb0};
            sync2  <= sync1;
            edge_d <= sync2[8:6];
        end
    end

    assign clk_s      = sync2[8];
    assign latch_s    = sync2[7];
    assign oe_s       = sync2[6];
    assign rgb1_s     = sync2[5:3];
    assign rgb0_s     = sync2[2:0];
    assign clk_rise   = clk_s & ~edge_d[2];
    assign latch_rise = latch_s & ~edge_d[1];
    assign oe_fall    = ~oe_s & edge_d[0];
    assign oe_rise    = oe_s & ~edge_d[0];
    assign cnt_bad    = too_many || (ptr != COLS_P);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A latch arriving in the handshake cycle refills the output immediately.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (latch_rise) begin
                    accept  = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (m_axis.tready) begin
                    state_d = OUT_EMPTY;
                    if (latch_rise) begin
                        accept  = 1'b1;
                        state_d = OUT_FULL;
                    end
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ptr      <= '0;
            too_many <= 1'b0;
            wbuf0    <= '0;
            wbuf1    <= '0;
        end else if (latch_rise) begin
            ptr      <= '0;
            too_many <= 1'b0;
        end else if (clk_rise) begin
            if (ptr < COLS_P) begin
                wbuf0[ptr[AW-1:0]] <= rgb0_s;
                wbuf1[ptr[AW-1:0]] <= rgb1_s;
                ptr                <= ptr + 1'b1;
            end else begin
                too_many <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            col0_q  <= '0;
            col1_q  <= '0;
            pix_q   <= '0;
            plane_q <= '0;
        end else if (accept) begin
            col0_q  <= wbuf0;
            col1_q  <= wbuf1;
            pix_q   <= too_many ? COLS_P : ptr;
            plane_q <= plane_cnt;
        end
    end

    // Long OE-high silence without shifting marks a frame gap: restart at plane 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            plane_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            if (!oe_s || clk_rise) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LIM) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (latch_rise) begin
                plane_cnt <= (plane_cnt == PLANE_LAST) ? '0 : plane_cnt + 1'b1;
            end else if (oe_s && !clk_rise && idle_cnt == IDLE_LIM) begin
                plane_cnt <= '0;
            end
        end
    end

    // The falling-edge cycle is itself a lit cycle, so the count starts at 1.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            timer         <= '0;
            on_time       <= '0;
            on_time_valid <= 1'b0;
        end else begin
            if (oe_fall) begin
                timer <= TIMER_W'(1);
            end else if (!oe_s && timer != '1) begin
                timer <= timer + 1'b1;
            end
            if (oe_rise) begin
                on_time <= timer;
            end
            on_time_valid <= oe_rise;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_count    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (accept && cnt_bad) begin
                err_count <= 1'b1;
            end else if (clear_err) begin
                err_count <= 1'b0;
            end
            if (latch_rise && !accept) begin
                err_overflow <= 1'b1;
            end else if (clear_err) begin
                err_overflow <= 1'b0;
            end
        end
    end

    assign m_axis.col_data0   = col0_q;
    assign m_axis.col_data1   = col1_q;
    assign m_axis.pix_count   = pix_q;
    assign m_axis.plane_index = plane_q;
    assign m_axis.tvalid      = (state_q == OUT_FULL);
endmodule
